// File: rtl/ste_debounce_pkg.sv
// Shared types for the multi-channel debouncer.
// The FSM encoding is fixed so that state dumps read the same across tools.
package ste_debounce_pkg;

    typedef enum logic [1:0] {
        ZERO = 2'd0,
        RISE = 2'd1,
        ONE  = 2'd2,
        FALL = 2'd3
    } deb_fsm_t;

endpackage

// File: rtl/ste_debounce_mc_if.sv
// Input/output bundle of the multi-channel debouncer.
// The application side drives the master modport; the debouncer is the slave.
interface ste_debounce_mc_if #(
    parameter int N_CH    = 4,
    parameter int CNT_W   = 4,
    parameter int PRESC_W = 8
);

    logic [N_CH-1:0]    din_i;
    logic [PRESC_W-1:0] presc_i;
    logic [CNT_W-1:0]   deb_rise_i;
    logic [CNT_W-1:0]   deb_fall_i;
    logic [N_CH-1:0]    dout_o;
    logic [N_CH-1:0]    rise_o;
    logic [N_CH-1:0]    fall_o;

    modport master (
        output din_i, presc_i, deb_rise_i, deb_fall_i,
        input  dout_o, rise_o, fall_o
    );

    modport slave (
        input  din_i, presc_i, deb_rise_i, deb_fall_i,
        output dout_o, rise_o, fall_o
    );

endinterface

// File: rtl/ste_debounce_ch.sv
// One debounce channel: optional synchroniser, 4-state FSM with tick-gated
// down-counter, registered level and one-cycle rise/fall pulses.
module ste_debounce_ch
    import ste_debounce_pkg::*;
#(
    parameter int SYNC  = 2,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset_i,
    input  logic             din,
    input  logic             tick,
    input  logic [CNT_W-1:0] deb_rise,
    input  logic [CNT_W-1:0] deb_fall,
    output logic             dout,
    output logic             rise,
    output logic             fall
);

    logic             ds;
    deb_fsm_t         state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dout_q, dout_d;
    logic             rise_q, fall_q;

    generate
        if (SYNC == 0) begin : g_nosync
            assign ds = din;
        end else begin : g_sync
            logic [SYNC-1:0] sync_q;

            // NOTE: synchroniser flops are reset too, so a pad held high through reset is seen as a fresh 0->1 edge.
            always_ff @(posedge clk or posedge reset_i) begin
                if (reset_i) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= din;
                    for (int i = 1; i < SYNC; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end

            assign ds = sync_q[SYNC-1];
        end
    endgenerate

    // NOTE: every always_comb output gets its hold value first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        case (state_q)
            ZERO: begin
                if (ds) begin
                    cnt_d   = deb_rise;
                    state_d = RISE;
                end
            end
            RISE: begin
                if (!ds) begin
                    state_d = ZERO;
                end else if (cnt_q == '0) begin
                    dout_d  = 1'b1;
                    state_d = ONE;
                end else if (tick) begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ONE: begin
                if (!ds) begin
                    cnt_d   = deb_fall;
                    state_d = FALL;
                end
            end
            FALL: begin
                if (ds) begin
                    state_d = ONE;
                end else if (cnt_q == '0) begin
                    dout_d  = 1'b0;
                    state_d = ZERO;
                end else if (tick) begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ZERO;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ZERO;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            rise_q  <= dout_d & ~dout_q;
            fall_q  <= ~dout_d & dout_q;
        end
    end

    assign dout = dout_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/ste_debounce_mc.sv
// Multi-channel debouncer top: shared tick prescaler feeding N_CH
// independent debounce channels.
module ste_debounce_mc #(
    parameter int N_CH    = 4,
    parameter int SYNC    = 2,
    parameter int CNT_W   = 4,
    parameter int PRESC_W = 8
) (
    input  logic              clk,
    input  logic              reset_i,
    ste_debounce_mc_if.slave  bus
);

    logic [PRESC_W-1:0] presc_cnt;
    logic               tick;
    logic [N_CH-1:0]    dout;
    logic [N_CH-1:0]    rise;
    logic [N_CH-1:0]    fall;

    // Reload value is only looked at on wrap, so presc_i changes apply at the next period.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            presc_cnt <= '0;
        end else if (presc_cnt == '0) begin
            presc_cnt <= bus.presc_i;
        end else begin
            presc_cnt <= presc_cnt - 1'b1;
        end
    end

    assign tick = (presc_cnt == '0);

    generate
        for (genvar n = 0; n < N_CH; n++) begin : g_ch
            ste_debounce_ch #(
                .SYNC  (SYNC),
                .CNT_W (CNT_W)
            ) u_ch (
                .clk      (clk),
                .reset_i  (reset_i),
                .din      (bus.din_i[n]),
                .tick     (tick),
                .deb_rise (bus.deb_rise_i),
                .deb_fall (bus.deb_fall_i),
                .dout     (dout[n]),
                .rise     (rise[n]),
                .fall     (fall[n])
            );
        end
    endgenerate

    assign bus.dout_o = dout;
    assign bus.rise_o = rise;
    assign bus.fall_o = fall;

endmodule
